mc_control: RTL and testbench
=============================

# mc_control

Multicycle control unit that drives the 32-bit ALU's `ALUop` and every datapath enable and mux select for a MIPS-subset multicycle CPU. It walks a Moore state machine per instruction (fetch, decode, execute, memory, writeback) from the opcode and funct fields held in the instruction register. It issues exactly the ALU operation encodings the ALU accepts and consumes the ALU's `Zero` flag for branches.

## Interface
- No parameters; all encodings are fixed constants in `mc_pkg`.
- `clk` in 1: single clock; all state changes occur on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]; stable from DECODE through the end of the instruction.
- `funct` in 6: IR[5:0]; same stability as `opcode`.
- `Zero` in 1: ALU zero flag, sampled only in state BEQ.
- `ALUop` out 4: ALU operation select.
- `ALUSrcA` out 1: 0 = PC, 1 = register A.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `IorD` out 1: memory address source; 0 = PC, 1 = ALUOut.
- Enables, `out 1` each: `MemRead`, `MemWrite`, `IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite`.
- `MemtoReg` out 1: register-file write data select; 1 = MDR.
- `RegDst` out 1: register-file write address select; 1 = rd.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: sticky flag, set on an unsupported opcode or funct.
- `retired` out 32: count of completed legal instructions.
- `state` out 4: current state, for debug.

## Operation
- ALUop encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- Supported R-type instructions (opcode 0x00), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
- Supported I-type and J-type opcodes: lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Any output not listed for a state is 0.
- FETCH: `MemRead`=1, `IRWrite`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=ADD, `PCSource`=00, `PCWrite`=1. Next state: DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=ADD (computes the branch target).
  - Next state by opcode: lw/sw → MEMADR, R-type → RTYPE_EX, beq → BEQ, j → JUMP, addi → ADDI_EX.
  - Illegal opcode, or R-type with an unsupported funct → FETCH; `illegal` is set at this edge.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=ADD. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Next state: MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next state: FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Next state: FETCH.
- RTYPE_EX: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=decode(funct). Next state: RTYPE_WB.
- RTYPE_WB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next state: FETCH.
- BEQ: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=SUB, `PCWriteCond`=1, `PCSource`=01. Next state: FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Next state: FETCH.
- ADDI_EX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=ADD. Next state: ADDI_WB.
- ADDI_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next state: FETCH.
- `retired` increments by 1 on the edge leaving each final state: MEMWB, MEMWR, RTYPE_WB, BEQ, JUMP, ADDI_WB.
  - `retired` wraps from 0xFFFFFFFF to 0.
  - An illegal instruction does not increment `retired`.
- `illegal` is cleared only by `rst`.

## Timing
- Outputs are combinational decodes of the state register. The only input feeding an output directly is `funct`, and only in RTYPE_EX.
- Cycles per instruction, FETCH through final state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- While `rst` is high:
  - state = FETCH, `retired` = 0, `illegal` = 0.
  - `MemRead`, `MemWrite`, `IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite` are forced to 0.
  - The muxes and `ALUop` show FETCH values (`ALUop`=0010, `ALUSrcB`=01).
- Reset asserted mid-instruction, in any state, aborts the instruction. The first rising edge after deassertion executes FETCH.
- `Zero` is sampled by the datapath in the BEQ cycle: PC is loaded from ALUOut iff `Zero`=1. The controller itself does not branch on `Zero`.

## Structure
- `mc_pkg` holds:
  - the state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ, JUMP, ADDI_EX, ADDI_WB;
  - the ALUop constants;
  - the opcode and funct constants;
  - the `ALUSrcB` and `PCSource` select encodings.
- One sub-module, `alu_decode`: combinational funct → {ALUop, valid}. DECODE uses `valid` for illegal detection; RTYPE_EX uses `ALUop`.

## Test plan
- Reset release, opcode=0x00, funct=0x20 (add):
  - states FETCH, DECODE, RTYPE_EX, RTYPE_WB;
  - `ALUop`=0010 in cycle 3; `RegWrite`=1 with `RegDst`=1 in cycle 4;
  - FETCH in cycle 5; `retired`=1.
- Each of funct 0x22, 0x24, 0x25, 0x27, 0x2A gives `ALUop` 0110, 0000, 0001, 1100, 0111 respectively in RTYPE_EX.
- lw (0x23):
  - 5 states;
  - MEMRD has `MemRead`=1 and `IorD`=1;
  - MEMWB has `MemtoReg`=1 and `RegWrite`=1.
- sw (0x2B): `MemWrite`=1 only in cycle 4; no `RegWrite` in any cycle.
- beq (0x04): BEQ state has `ALUop`=0110, `PCWriteCond`=1, `PCSource`=01, with identical outputs for `Zero`=0 and `Zero`=1. j (0x02): `PCWrite`=1 and `PCSource`=10 in cycle 3.
- Illegal and reset cases:
  - opcode=0x3F → FETCH after DECODE, `illegal`=1 and stays 1, `retired` unchanged;
  - R-type funct=0x00 → same behaviour;
  - `rst` pulsed during MEMRD → state FETCH and all enables 0 while `rst` is high, `illegal`=0, `retired`=0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: state, ALU, opcode/funct and mux-select encodings for the multicycle controller
package mc_pkg;
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] RTYPE_EX = 4'd6;
  localparam logic [3:0] RTYPE_WB = 4'd7;
  localparam logic [3:0] BEQ      = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] ADDI_EX  = 4'd10;
  localparam logic [3:0] ADDI_WB  = 4'd11;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
endpackage

// File: rtl/mc_control_alu_decode.sv
// alu_decode: maps an R-type funct field to its ALU operation and a supported flag
module alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);
  // unsupported functs fall back to ADD; valid=0 keeps them out of RTYPE_EX
  always_comb begin
    alu_op = funct == F_SUB ? ALU_SUB :
             funct == F_AND ? ALU_AND :
             funct == F_OR  ? ALU_OR  :
             funct == F_NOR ? ALU_NOR :
             funct == F_SLT ? ALU_SLT : ALU_ADD;
    valid  = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: Moore FSM driving ALU op, datapath enables and mux selects of a multicycle MIPS-subset CPU
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        Zero,
  output logic [3:0]  ALUop,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic [1:0]  PCSource,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state
);
  logic [3:0]  state_q, state_d;
  logic [31:0] retired_q;
  logic        illegal_q;
  logic [3:0]  f_alu_op;
  logic        f_valid, legal, done;
  logic        unused_zero;
  alu_decode u_alu_decode (.funct(funct), .alu_op(f_alu_op), .valid(f_valid));
  // Zero steers the PC in the datapath only; the controller never branches on it
  assign unused_zero = Zero;
  // instruction legality and next-state selection
  always_comb begin
    legal   = opcode inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J} || (opcode == OP_RTYPE && f_valid);
    done    = state_q inside {MEMWB, MEMWR, RTYPE_WB, BEQ, JUMP, ADDI_WB};
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = !legal                              ? FETCH    :
                          (opcode == OP_LW || opcode == OP_SW) ? MEMADR   :
                          opcode == OP_RTYPE                   ? RTYPE_EX :
                          opcode == OP_BEQ                     ? BEQ      :
                          opcode == OP_J                       ? JUMP     : ADDI_EX;
      MEMADR:   state_d = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      RTYPE_EX: state_d = RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
  end
  // state, retired counter and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_q + 32'(done);
      illegal_q <= illegal_q | (state_q == DECODE && !legal);
    end
  end
  // Moore output decode; enables are held low while reset is asserted
  always_comb begin
    ALUop       = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUop   = ALU_ADD;
        PCWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM2;
        ALUop   = ALU_ADD;
      end
      MEMADR, ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALU_ADD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUop   = f_alu_op;
      end
      RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_OUT;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      ADDI_WB:  RegWrite = 1'b1;
      default:  ALUop = '0;
    endcase
    if (rst) begin
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
    end
  end
  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench checking per-cycle state/outputs, retired count and illegal flag
module tb_mc_control;
  import mc_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, Zero = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [3:0]  ALUop, state;
  logic [1:0]  ALUSrcB, PCSource;
  logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, MemtoReg, RegDst, illegal;
  logic [31:0] retired;
  typedef logic [21:0] vec_t;
  vec_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_retired = '0;
  logic        exp_illegal = 1'b0;
  mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .PCSource(PCSource), .illegal(illegal), .retired(retired), .state(state)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic vec_t obs();
    return {state, ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
            PCWriteCond, RegWrite, MemtoReg, RegDst, PCSource};
  endfunction
  function automatic logic f_ok(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  endfunction
  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h27:   return 4'b1100;
      6'h2A:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction
  // {ALUop, SrcA, SrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, MemtoReg, RegDst, PCSource}
  function automatic logic [17:0] exp_out(input logic [3:0] st, input logic [5:0] f);
    case (st)
      FETCH:    return 18'b0010_0_01_0_101100_00_00;
      DECODE:   return 18'b0010_0_11_0_000000_00_00;
      MEMADR:   return 18'b0010_1_10_0_000000_00_00;
      MEMRD:    return 18'b0000_0_00_1_100000_00_00;
      MEMWB:    return 18'b0000_0_00_0_000001_10_00;
      MEMWR:    return 18'b0000_0_00_1_010000_00_00;
      RTYPE_EX: return {alu_of(f), 14'b1_00_0_000000_00_00};
      RTYPE_WB: return 18'b0000_0_00_0_000001_01_00;
      BEQ:      return 18'b0110_1_00_0_000010_00_01;
      JUMP:     return 18'b0000_0_00_0_000100_00_10;
      ADDI_EX:  return 18'b0010_1_10_0_000000_00_00;
      ADDI_WB:  return 18'b0000_0_00_0_000001_00_00;
      default:  return 18'h3FFFF;
    endcase
  endfunction
  task automatic push_instr(input logic [5:0] op, input logic [5:0] f);
    logic [3:0] seq[$];
    opcode = op;
    funct  = f;
    seq = {FETCH, DECODE};
    case (op)
      6'h00:   if (f_ok(f)) seq = {seq, RTYPE_EX, RTYPE_WB};
      6'h23:   seq = {seq, MEMADR, MEMRD, MEMWB};
      6'h2B:   seq = {seq, MEMADR, MEMWR};
      6'h04:   seq = {seq, BEQ};
      6'h02:   seq = {seq, JUMP};
      6'h08:   seq = {seq, ADDI_EX, ADDI_WB};
      default: ;
    endcase
    if (seq.size() > 2) exp_retired = exp_retired + 1;
    else exp_illegal = 1'b1;
    foreach (seq[i]) sb.push_back({seq[i], exp_out(seq[i], f)});
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    vec_t e;
    repeat (2) tick();
    e = {FETCH, 18'b0010_0_01_0_000000_00_00};
    n_tests++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
    n_tests++;
    if (retired !== 32'd0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: got retired=%0d illegal=%b want 0/0", retired, illegal);
    end
    rst = 1'b0;
    #1;
  endtask
  task automatic test_rtype();
    logic [5:0] fs[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    vec_t e;
    foreach (fs[k]) begin
      push_instr(6'h00, fs[k]);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL rtype f=%h: got %h want %h", fs[k], obs(), e); end
        tick();
      end
      n_tests++;
      if (retired !== exp_retired || state !== FETCH) begin
        n_fail++; $display("FAIL rtype_retire f=%h: got retired=%0d state=%0d want %0d/%0d", fs[k], retired, state, exp_retired, FETCH);
      end
    end
  endtask
  task automatic test_mem();
    logic [5:0] ops[2] = '{6'h23, 6'h2B};
    vec_t e;
    foreach (ops[k]) begin
      push_instr(ops[k], 6'h15);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL mem op=%h: got %h want %h", ops[k], obs(), e); end
        tick();
      end
      n_tests++;
      if (retired !== exp_retired) begin n_fail++; $display("FAIL mem_retire op=%h: got %0d want %0d", ops[k], retired, exp_retired); end
    end
  endtask
  task automatic test_branch();
    logic [5:0] ops[4] = '{6'h04, 6'h04, 6'h02, 6'h08};
    vec_t e;
    foreach (ops[k]) begin
      Zero = k[0];
      push_instr(ops[k], 6'h2A);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL branch op=%h zero=%b: got %h want %h", ops[k], Zero, obs(), e); end
        tick();
      end
      n_tests++;
      if (retired !== exp_retired) begin n_fail++; $display("FAIL branch_retire op=%h: got %0d want %0d", ops[k], retired, exp_retired); end
    end
    Zero = 1'b0;
  endtask
  task automatic test_illegal();
    logic [5:0] ops[3] = '{6'h3F, 6'h00, 6'h00};
    logic [5:0] fs[3]  = '{6'h20, 6'h00, 6'h20};
    vec_t e;
    foreach (ops[k]) begin
      push_instr(ops[k], fs[k]);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL illegal op=%h f=%h: got %h want %h", ops[k], fs[k], obs(), e); end
        tick();
      end
      n_tests++;
      if (illegal !== exp_illegal || retired !== exp_retired || state !== FETCH) begin
        n_fail++;
        $display("FAIL illegal_flag op=%h f=%h: got ill=%b ret=%0d st=%0d want %b/%0d/%0d", ops[k], fs[k], illegal, retired, state, exp_illegal, exp_retired, FETCH);
      end
    end
  endtask
  task automatic test_reset_mid();
    vec_t e, r;
    r = {FETCH, 18'b0010_0_01_0_000000_00_00};
    push_instr(6'h23, 6'h00);
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL rstmid_pre cyc%0d: got %h want %h", i, obs(), e); end
      if (i < 3) tick();
    end
    sb.delete();
    rst = 1'b1;
    #1;
    exp_retired = '0;
    exp_illegal = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (obs() !== r || illegal !== 1'b0 || retired !== 32'd0) begin
        n_fail++; $display("FAIL rstmid_hold %0d: got %h ill=%b ret=%0d want %h 0 0", i, obs(), illegal, retired, r);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    push_instr(6'h00, 6'h25);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e) begin n_fail++; $display("FAIL rstmid_post: got %h want %h", obs(), e); end
      tick();
    end
    n_tests++;
    if (retired !== 32'd1 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_retire: got ret=%0d ill=%b want 1/0", retired, illegal);
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
